// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the commit trace buffer:
//   - trace_state_t : capture FSM state encoding (IDLE/ARMED/CAPTURE/DONE)
//   - MODE_*        : capture mode encodings driven on the mode input
//   - entry_w()     : width of one stored trace entry as a function of XLEN
//   - off_*()       : bit offsets of each field inside a packed entry
// Entry layout, MSB first: {pc, instr[31:0], rd[4:0], regwrite, wdata}.
// -----------------------------------------------------------------------------
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_t;

    localparam logic [1:0] MODE_FREE      = 2'd0;
    localparam logic [1:0] MODE_STOP_FULL = 2'd1;
    localparam logic [1:0] MODE_TRIG      = 2'd2;
    localparam logic [1:0] MODE_RSVD      = 2'd3;

    localparam int OFF_WDATA = 0;

    function automatic int entry_w(input int xlen);
        return 2 * xlen + 38;
    endfunction

    function automatic int off_regwrite(input int xlen);
        return xlen;
    endfunction

    function automatic int off_rd(input int xlen);
        return xlen + 1;
    endfunction

    function automatic int off_instr(input int xlen);
        return xlen + 6;
    endfunction

    function automatic int off_pc(input int xlen);
        return xlen + 38;
    endfunction

endpackage

// File: rtl/trace_mem.sv
// -----------------------------------------------------------------------------
// trace_mem
// Entry storage for the trace buffer: DEPTH x WIDTH register array with one
// synchronous write port and one combinational read port. The array has no
// reset; the owner guarantees stale contents are never presented.
// Ports:
//   i_clk    : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational from i_raddr)
// -----------------------------------------------------------------------------
module trace_mem
    import trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = entry_w(64),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/trace_buffer.sv
// -----------------------------------------------------------------------------
// trace_buffer
// Captures retired-instruction commit records into a circular buffer and
// replays them oldest-first through a valid/ready port once capture is done.
// Modes: FREE (wrap and count overflow), STOP_FULL (stop when full),
// TRIG (wait for trig_pc, then capture POST entries including the trigger).
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   commit_*          : one retired instruction per cycle when commit_valid
//   mode, trig_pc     : capture mode (sampled at arm) and trigger PC
//   arm, stop, clear  : control strobes, priority clear > stop > arm > commit
//   rd_valid/ready    : readout handshake, active only in DONE
//   rd_data           : {pc, instr, rd, regwrite, wdata} of oldest entry
//   state, count      : FSM state and number of stored entries
//   overflow          : saturating count of overwritten entries (FREE/TRIG)
//   triggered         : trigger PC has been seen since the last arm/clear
// -----------------------------------------------------------------------------
module trace_buffer
    import trace_pkg::*;
#(
    parameter  int XLEN    = 64,
    parameter  int DEPTH   = 16,
    parameter  int POST    = 8,
    localparam int ENTRY_W = entry_w(XLEN),
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               commit_valid,
    input  logic [XLEN-1:0]    commit_pc,
    input  logic [31:0]        commit_instr,
    input  logic [4:0]         commit_rd,
    input  logic [XLEN-1:0]    commit_wdata,
    input  logic               commit_regwrite,
    input  logic [1:0]         mode,
    input  logic [XLEN-1:0]    trig_pc,
    input  logic               arm,
    input  logic               stop,
    input  logic               clear,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [1:0]         state,
    output logic [CW-1:0]      count,
    output logic [15:0]        overflow,
    output logic               triggered
);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] POST_M1  = CW'(POST - 1);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    trace_state_t    r_state, w_state_nxt;
    logic [1:0]      r_mode, w_mode_nxt;
    logic [AW-1:0]   r_wptr, w_wptr_nxt;
    logic [AW-1:0]   r_rptr, w_rptr_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic [15:0]     r_overflow, w_overflow_nxt;
    logic            r_triggered, w_triggered_nxt;
    logic [CW-1:0]   r_post_left, w_post_left_nxt;

    logic               w_we;
    logic               w_rd_valid;
    logic               w_pop;
    logic               w_full;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_mem_rdata;

    assign w_entry    = {commit_pc, commit_instr, commit_rd, commit_regwrite, commit_wdata};
    assign w_rd_valid = (r_state == ST_DONE) && (r_count != '0);
    assign w_pop      = w_rd_valid && rd_ready;
    assign w_full     = (r_count == DEPTH_C);

    trace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (w_entry),
        .i_raddr (r_rptr),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_FREE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= '0;
            r_triggered <= 1'b0;
            r_post_left <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode      <= w_mode_nxt;
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= w_overflow_nxt;
            r_triggered <= w_triggered_nxt;
            r_post_left <= w_post_left_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mode_nxt      = r_mode;
        w_wptr_nxt      = r_wptr;
        w_rptr_nxt      = r_rptr;
        w_count_nxt     = r_count;
        w_overflow_nxt  = r_overflow;
        w_triggered_nxt = r_triggered;
        w_post_left_nxt = r_post_left;
        w_we            = 1'b0;

        if (clear) begin
            w_state_nxt     = ST_IDLE;
            w_wptr_nxt      = '0;
            w_rptr_nxt      = '0;
            w_count_nxt     = '0;
            w_overflow_nxt  = '0;
            w_triggered_nxt = 1'b0;
            w_post_left_nxt = '0;
        end else if (stop && (r_state == ST_ARMED || r_state == ST_CAPTURE)) begin
            w_state_nxt = ST_DONE;
        end else if (arm && (r_state == ST_IDLE || r_state == ST_DONE)) begin
            w_wptr_nxt      = '0;
            w_rptr_nxt      = '0;
            w_count_nxt     = '0;
            w_overflow_nxt  = '0;
            w_triggered_nxt = 1'b0;
            w_post_left_nxt = '0;
            w_mode_nxt      = mode;
            w_state_nxt     = (mode == MODE_TRIG) ? ST_ARMED : ST_CAPTURE;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    // Buffer is empty here, so the trigger entry never overwrites.
                    if (commit_valid && (commit_pc == trig_pc)) begin
                        w_we            = 1'b1;
                        w_wptr_nxt      = r_wptr + 1'b1;
                        w_count_nxt     = r_count + 1'b1;
                        w_triggered_nxt = 1'b1;
                        w_post_left_nxt = POST_M1;
                        w_state_nxt     = (POST == 1) ? ST_DONE : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (commit_valid) begin
                        w_we       = 1'b1;
                        w_wptr_nxt = r_wptr + 1'b1;
                        // STOP_FULL leaves CAPTURE before it can ever be full.
                        if (w_full && (r_mode != MODE_STOP_FULL)) begin
                            w_rptr_nxt     = r_rptr + 1'b1;
                            w_overflow_nxt = (r_overflow == 16'hFFFF) ? r_overflow
                                                                      : r_overflow + 16'd1;
                        end else begin
                            w_count_nxt = r_count + 1'b1;
                        end

                        if (r_mode == MODE_STOP_FULL) begin
                            if (r_count == DEPTH_C - 1'b1) begin
                                w_state_nxt = ST_DONE;
                            end
                        end else if (r_mode == MODE_TRIG) begin
                            // post_left counts entries still owed after the trigger;
                            // the write that exhausts it closes the capture window.
                            if (r_post_left <= ONE_C) begin
                                w_post_left_nxt = '0;
                                w_state_nxt     = ST_DONE;
                            end else begin
                                w_post_left_nxt = r_post_left - 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (w_pop) begin
                        w_rptr_nxt  = r_rptr + 1'b1;
                        w_count_nxt = r_count - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_valid  = w_rd_valid;
    assign rd_data   = w_rd_valid ? w_mem_rdata : '0;
    assign state     = r_state;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign triggered = r_triggered;

endmodule
